// File: rtl/tmr_pkg.sv
// -----------------------------------------------------------------------------
// tmr_pkg
// Shared types and helpers for the TMR voter/monitor.
//   tmr_mode_t : voting mode derived from how many lanes are retired
//   LANE_A/B/C : lane indices into fault_flags / sticky_flags / lane_failed
//   mode_of()  : maps a lane_failed vector to the voting mode
// -----------------------------------------------------------------------------
package tmr_pkg;

  localparam int NUM_LANES = 3;
  localparam int LANE_A    = 0;
  localparam int LANE_B    = 1;
  localparam int LANE_C    = 2;

  typedef enum logic [1:0] {
    MODE_TMR  = 2'd0,  // all three lanes healthy: bitwise majority
    MODE_DMR  = 2'd1,  // one lane retired: compare the healthy pair
    MODE_LOST = 2'd2   // two or more retired: no vote possible
  } tmr_mode_t;

  function automatic tmr_mode_t mode_of(input logic [NUM_LANES-1:0] lane_failed);
    int n_failed;
    n_failed = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      n_failed += int'(lane_failed[i]);
    end
    case (n_failed)
      0:       mode_of = MODE_TMR;
      1:       mode_of = MODE_DMR;
      default: mode_of = MODE_LOST;
    endcase
  endfunction

endpackage

// File: rtl/tmr_lane_health.sv
// -----------------------------------------------------------------------------
// tmr_lane_health
// Health tracker for one redundant lane: a saturating mismatch counter and a
// consecutive-mismatch counter that retires the lane at FAIL_THRESH.
//   clk, rst_n : clock, asynchronous active-low reset
//   upd        : a valid sample is being voted this cycle
//   mismatch   : this lane disagreed with the voted result
//   clear      : synchronous clear of counters and the failed flag (wins over upd)
//   err_cnt    : saturating mismatch count (frozen once failed)
//   failed     : lane retired; sticky until clear
// -----------------------------------------------------------------------------
module tmr_lane_health #(
  parameter int ERR_CNT_W   = 16,
  parameter int FAIL_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 upd,
  input  logic                 mismatch,
  input  logic                 clear,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 failed
);

  // consec never exceeds FAIL_THRESH, which fits in ERR_CNT_W bits.
  localparam logic [ERR_CNT_W-1:0] THRESH_M1 = ERR_CNT_W'(FAIL_THRESH - 1);

  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_CNT_W-1:0] consec_q, consec_d;
  logic                 failed_q, failed_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    err_cnt_d = err_cnt_q;
    consec_d  = consec_q;
    failed_d  = failed_q;
    if (clear) begin
      err_cnt_d = '0;
      consec_d  = '0;
      failed_d  = 1'b0;
    end else if (upd && !failed_q) begin
      if (mismatch) begin
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
        consec_d = consec_q + 1'b1;
        if (consec_q == THRESH_M1) begin
          failed_d = 1'b1;
        end
      end else begin
        consec_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) begin
      err_cnt_q <= '0;
      consec_q  <= '0;
      failed_q  <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      consec_q  <= consec_d;
      failed_q  <= failed_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign failed  = failed_q;

endmodule

// File: rtl/tmr_voter_monitor.sv
// -----------------------------------------------------------------------------
// tmr_voter_monitor
// 2-of-3 majority voter with per-lane health tracking. Degrades to a pair
// compare after one lane is retired and holds its output once two are retired.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid            : input_a/b/c carry a sample this cycle
//   input_a/b/c         : redundant lane data
//   clear               : pulse; clears sticky flags, counters and lane_failed
//   voted_output        : registered voted data
//   out_valid           : one-cycle pulse per voted sample
//   disagreement        : the non-failed lanes did not all agree
//   uncorrectable       : no majority formed; voted_output held
//   fault_flags         : per sample, lane mismatched the output or is failed
//   sticky_flags        : OR of fault_flags since reset or clear
//   lane_failed         : retired lanes
//   err_cnt             : {c,b,a} saturating mismatch counts
// Latency in_valid -> out_valid is 1 + INPUT_REG cycles.
// -----------------------------------------------------------------------------
module tmr_voter_monitor
  import tmr_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int ERR_CNT_W   = 16,
  parameter int FAIL_THRESH = 4,
  parameter int INPUT_REG   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       input_a,
  input  logic [WIDTH-1:0]       input_b,
  input  logic [WIDTH-1:0]       input_c,
  input  logic                   clear,
  output logic [WIDTH-1:0]       voted_output,
  output logic                   out_valid,
  output logic                   disagreement,
  output logic                   uncorrectable,
  output logic [2:0]             fault_flags,
  output logic [2:0]             sticky_flags,
  output logic [2:0]             lane_failed,
  output logic [3*ERR_CNT_W-1:0] err_cnt
);

  // ---------------------------------------------------------------------------
  // Optional input stage. clear is deliberately not delayed: it acts on
  // whatever sample is at the vote stage in the cycle it is asserted.
  // ---------------------------------------------------------------------------
  logic             v_s;
  logic [WIDTH-1:0] a_s, b_s, c_s;

  if (INPUT_REG != 0) begin : g_in_reg
    logic             v_q;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        c_q <= '0;
      end else begin
        v_q <= in_valid;
        a_q <= input_a;
        b_q <= input_b;
        c_q <= input_c;
      end
    end
    assign v_s = v_q;
    assign a_s = a_q;
    assign b_s = b_q;
    assign c_s = c_q;
  end else begin : g_no_reg
    assign v_s = in_valid;
    assign a_s = input_a;
    assign b_s = input_b;
    assign c_s = input_c;
  end

  // ---------------------------------------------------------------------------
  // Vote / compare. Mode comes from lane_failed as it stands before this
  // sample, so a lane retired by this sample still takes part in its vote.
  // ---------------------------------------------------------------------------
  logic [2:0]       failed_w;
  tmr_mode_t        mode;
  logic [WIDTH-1:0] maj;
  logic [WIDTH-1:0] pair_x, pair_y;
  logic [2:0]       mism;

  logic [WIDTH-1:0] voted_q, voted_d;
  logic             dis_q, dis_d;
  logic             unc_q, unc_d;
  logic [2:0]       ff_q, ff_d;
  logic [2:0]       sticky_q, sticky_d;
  logic             ov_q;

  assign mode = mode_of(failed_w);
  assign maj  = (a_s & b_s) | (a_s & c_s) | (b_s & c_s);

  // Healthy pair for DMR: the two lanes other than the retired one.
  always_comb begin
    pair_x = a_s;
    pair_y = b_s;
    if (failed_w[LANE_A]) begin
      pair_x = b_s;
      pair_y = c_s;
    end else if (failed_w[LANE_B]) begin
      pair_x = a_s;
      pair_y = c_s;
    end
  end

  always_comb begin
    voted_d = voted_q;
    dis_d   = dis_q;
    unc_d   = unc_q;
    ff_d    = ff_q;
    mism    = '0;
    if (v_s) begin
      case (mode)
        MODE_TMR: begin
          voted_d      = maj;
          mism[LANE_A] = (a_s != maj);
          mism[LANE_B] = (b_s != maj);
          mism[LANE_C] = (c_s != maj);
          dis_d        = (a_s != b_s) || (b_s != c_s);
          unc_d        = 1'b0;
        end
        MODE_DMR: begin
          // No lane can be blamed when only two remain, so mism stays 0.
          if (pair_x == pair_y) begin
            voted_d = pair_x;
            dis_d   = 1'b0;
            unc_d   = 1'b0;
          end else begin
            dis_d   = 1'b1;
            unc_d   = 1'b1;
          end
        end
        default: begin
          dis_d = 1'b0;
          unc_d = 1'b1;
        end
      endcase
      ff_d = mism | failed_w;
    end
  end

  // clear wins over the OR-in of the sample voted in the same cycle.
  assign sticky_d = clear ? 3'b000 : (sticky_q | (v_s ? ff_d : 3'b000));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voted_q  <= '0;
      dis_q    <= 1'b0;
      unc_q    <= 1'b0;
      ff_q     <= '0;
      sticky_q <= '0;
      ov_q     <= 1'b0;
    end else begin
      voted_q  <= voted_d;
      dis_q    <= dis_d;
      unc_q    <= unc_d;
      ff_q     <= ff_d;
      sticky_q <= sticky_d;
      ov_q     <= v_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane health; its registers update on the same edge as the outputs,
  // so err_cnt / lane_failed line up with the sample's out_valid.
  // ---------------------------------------------------------------------------
  logic [ERR_CNT_W-1:0] err_w [NUM_LANES];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    tmr_lane_health #(
      .ERR_CNT_W  (ERR_CNT_W),
      .FAIL_THRESH(FAIL_THRESH)
    ) u_health (
      .clk     (clk),
      .rst_n   (rst_n),
      .upd     (v_s),
      .mismatch(mism[l]),
      .clear   (clear),
      .err_cnt (err_w[l]),
      .failed  (failed_w[l])
    );
  end

  assign voted_output  = voted_q;
  assign out_valid     = ov_q;
  assign disagreement  = dis_q;
  assign uncorrectable = unc_q;
  assign fault_flags   = ff_q;
  assign sticky_flags  = sticky_q;
  assign lane_failed   = failed_w;
  assign err_cnt       = {err_w[LANE_C], err_w[LANE_B], err_w[LANE_A]};

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// -----------------------------------------------------------------------------
// tb_tmr_voter_monitor
// Two instances share one stimulus stream:
//   dut0 : defaults (ERR_CNT_W=16, FAIL_THRESH=4, INPUT_REG=0)
//   dut1 : ERR_CNT_W=2, FAIL_THRESH=3, INPUT_REG=1
// A behavioural model per instance predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_tmr_voter_monitor;

  localparam logic [63:0] K = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        clear;
  logic [63:0] a, b, c;

  always #5 clk = ~clk;

  logic [63:0] o0_voted, o1_voted;
  logic        o0_ov, o1_ov, o0_dis, o1_dis, o0_unc, o1_unc;
  logic [2:0]  o0_ff, o1_ff, o0_st, o1_st, o0_lf, o1_lf;
  logic [47:0] o0_err;
  logic [5:0]  o1_err;

  tmr_voter_monitor #(.WIDTH(64), .ERR_CNT_W(16), .FAIL_THRESH(4), .INPUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .input_a(a), .input_b(b), .input_c(c), .clear(clear),
    .voted_output(o0_voted), .out_valid(o0_ov), .disagreement(o0_dis),
    .uncorrectable(o0_unc), .fault_flags(o0_ff), .sticky_flags(o0_st),
    .lane_failed(o0_lf), .err_cnt(o0_err)
  );

  tmr_voter_monitor #(.WIDTH(64), .ERR_CNT_W(2), .FAIL_THRESH(3), .INPUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .input_a(a), .input_b(b), .input_c(c), .clear(clear),
    .voted_output(o1_voted), .out_valid(o1_ov), .disagreement(o1_dis),
    .uncorrectable(o1_unc), .fault_flags(o1_ff), .sticky_flags(o1_st),
    .lane_failed(o1_lf), .err_cnt(o1_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain counters and per-bit vote counting.
  // ---------------------------------------------------------------------------
  int          cnt_max [2] = '{65535, 3};
  int          thresh  [2] = '{4, 3};
  int          ew      [2] = '{16, 2};
  bit          ireg    [2] = '{1'b0, 1'b1};

  int          m_err    [2][3];
  int          m_consec [2][3];
  bit          m_failed [2][3];
  logic [63:0] m_voted  [2];
  bit          m_dis [2], m_unc [2], m_ov [2];
  bit   [2:0]  m_ff  [2], m_sticky [2];
  bit          m_pv  [2];
  logic [63:0] m_pa [2], m_pb [2], m_pc [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int l = 0; l < 3; l++) begin
        m_err[i][l] = 0; m_consec[i][l] = 0; m_failed[i][l] = 1'b0;
      end
      m_voted[i] = '0; m_dis[i] = 0; m_unc[i] = 0; m_ov[i] = 0;
      m_ff[i] = '0; m_sticky[i] = '0;
      m_pv[i] = 0; m_pa[i] = '0; m_pb[i] = '0; m_pc[i] = '0;
    end
  endtask

  task automatic model_tick(input int i, input bit v, input logic [63:0] xa,
                            input logic [63:0] xb, input logic [63:0] xc, input bit clr);
    bit          sv;
    logic [63:0] s [3];
    logic [63:0] maj;
    int          nf, ones, k;
    int          healthy [2];
    bit   [2:0]  mism, pre_failed;
    if (ireg[i]) begin
      sv = m_pv[i]; s[0] = m_pa[i]; s[1] = m_pb[i]; s[2] = m_pc[i];
      m_pv[i] = v; m_pa[i] = xa; m_pb[i] = xb; m_pc[i] = xc;
    end else begin
      sv = v; s[0] = xa; s[1] = xb; s[2] = xc;
    end
    m_ov[i] = sv;
    nf = 0;
    for (int l = 0; l < 3; l++) begin
      pre_failed[l] = m_failed[i][l];
      nf += int'(m_failed[i][l]);
    end
    mism = '0;
    if (sv) begin
      if (nf == 0) begin
        for (int j = 0; j < 64; j++) begin
          ones = int'(s[0][j]) + int'(s[1][j]) + int'(s[2][j]);
          maj[j] = (ones >= 2);
        end
        for (int l = 0; l < 3; l++) mism[l] = (s[l] != maj);
        m_voted[i] = maj;
        m_dis[i]   = !(s[0] == s[1] && s[1] == s[2]);
        m_unc[i]   = 0;
      end else if (nf == 1) begin
        k = 0;
        for (int l = 0; l < 3; l++) if (!m_failed[i][l]) begin healthy[k] = l; k++; end
        if (s[healthy[0]] == s[healthy[1]]) begin
          m_voted[i] = s[healthy[0]]; m_dis[i] = 0; m_unc[i] = 0;
        end else begin
          m_dis[i] = 1; m_unc[i] = 1;
        end
      end else begin
        m_dis[i] = 0; m_unc[i] = 1;
      end
      m_ff[i] = mism | pre_failed;
      if (!clr) begin
        for (int l = 0; l < 3; l++) begin
          if (!m_failed[i][l]) begin
            if (mism[l]) begin
              if (m_err[i][l] < cnt_max[i]) m_err[i][l]++;
              m_consec[i][l]++;
              if (m_consec[i][l] >= thresh[i]) m_failed[i][l] = 1'b1;
            end else begin
              m_consec[i][l] = 0;
            end
          end
        end
      end
      m_sticky[i] |= m_ff[i];
    end
    if (clr) begin
      m_sticky[i] = '0;
      for (int l = 0; l < 3; l++) begin
        m_err[i][l] = 0; m_consec[i][l] = 0; m_failed[i][l] = 1'b0;
      end
    end
  endtask

  task automatic check_dut(input int i, input logic ov, input logic [63:0] voted,
                           input logic dis, input logic unc, input logic [2:0] ff,
                           input logic [2:0] st, input logic [2:0] lf,
                           input logic [63:0] errv);
    logic [63:0] exp_err;
    logic [2:0]  exp_lf;
    exp_err = '0;
    for (int l = 0; l < 3; l++) begin
      exp_err |= 64'(m_err[i][l]) << (l * ew[i]);
      exp_lf[l] = m_failed[i][l];
    end
    check($sformatf("d%0d.out_valid", i), 64'(ov), 64'(m_ov[i]));
    check($sformatf("d%0d.voted", i), voted, m_voted[i]);
    check($sformatf("d%0d.disagreement", i), 64'(dis), 64'(m_dis[i]));
    check($sformatf("d%0d.uncorrectable", i), 64'(unc), 64'(m_unc[i]));
    check($sformatf("d%0d.fault_flags", i), 64'(ff), 64'(m_ff[i]));
    check($sformatf("d%0d.sticky_flags", i), 64'(st), 64'(m_sticky[i]));
    check($sformatf("d%0d.lane_failed", i), 64'(lf), 64'(exp_lf));
    check($sformatf("d%0d.err_cnt", i), errv, exp_err);
  endtask

  task automatic compare_all();
    check_dut(0, o0_ov, o0_voted, o0_dis, o0_unc, o0_ff, o0_st, o0_lf, 64'(o0_err));
    check_dut(1, o1_ov, o1_voted, o1_dis, o1_unc, o1_ff, o1_st, o1_lf, 64'(o1_err));
  endtask

  // Drive one cycle, advance the models at the edge, compare at the negedge.
  task automatic cycle(input bit v, input logic [63:0] xa, input logic [63:0] xb,
                       input logic [63:0] xc, input bit clr);
    in_valid = v; a = xa; b = xb; c = xc; clear = clr;
    @(posedge clk);
    model_tick(0, v, xa, xb, xc, clr);
    model_tick(1, v, xa, xb, xc, clr);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [63:0] base, la, lb, lc;
    int          bad;

    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; a = '0; b = '0; c = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("reset.voted", o0_voted, 64'h0);
    check("reset.err_cnt", 64'(o1_err), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean sample: same value out after one cycle, all flags 0.
    cycle(1, K, K, K, 0);
    check("clean.out_valid", 64'(o0_ov), 64'h1);
    check("clean.voted", o0_voted, K);
    check("clean.fault_flags", 64'(o0_ff), 64'h0);
    cycle(0, '0, '0, '0, 0);
    check("clean.pulse", 64'(o0_ov), 64'h0);

    // Single-bit error on B.
    cycle(1, K, K ^ 64'h1, K, 0);
    check("b_err.voted", o0_voted, K);
    check("b_err.disagreement", 64'(o0_dis), 64'h1);
    check("b_err.fault_flags", 64'(o0_ff), 64'h2);
    check("b_err.err_cnt_b", 64'(o0_err[31:16]), 64'h1);
    check("b_err.sticky", 64'(o0_st), 64'h2);
    cycle(1, K, K, K, 0);
    check("b_ok.fault_flags", 64'(o0_ff), 64'h0);
    check("b_ok.sticky", 64'(o0_st), 64'h2);

    // C wrong for four consecutive samples retires C in dut0.
    for (int n = 0; n < 4; n++) begin
      cycle(1, K, K, ~K, 0);
      if (n == 2) check("c_fail.before", 64'(o0_lf), 64'h0);
    end
    check("c_fail.lane_failed", 64'(o0_lf), 64'h4);
    cycle(1, 64'd5, 64'd5, 64'd9, 0);
    check("dmr_eq.voted", o0_voted, 64'd5);
    check("dmr_eq.uncorrectable", 64'(o0_unc), 64'h0);
    check("dmr_eq.fault_flags", 64'(o0_ff), 64'h4);
    cycle(1, 64'd5, 64'd6, 64'd9, 0);
    check("dmr_ne.voted", o0_voted, 64'd5);
    check("dmr_ne.disagreement", 64'(o0_dis), 64'h1);
    check("dmr_ne.uncorrectable", 64'(o0_unc), 64'h1);
    check("dmr_ne.err_cnt_ab", 64'(o0_err[31:0]), 64'h0001_0000);
    cycle(1, 64'd7, 64'd7, 64'd9, 0);
    check("dmr_eq2.voted", o0_voted, 64'd7);

    // Clear, then lane A alternating wrong/right: dut1's 2-bit counter saturates.
    cycle(0, '0, '0, '0, 1);
    for (int n = 0; n < 10; n++) begin
      cycle(1, (n % 2 == 0) ? (K ^ 64'h8) : K, K, K, 0);
    end
    cycle(0, '0, '0, '0, 0);
    check("sat.err_cnt_a", 64'(o1_err[1:0]), 64'h3);
    check("sat.lane_failed", 64'(o1_lf), 64'h0);
    check("sat.dut0_err_a", 64'(o0_err[15:0]), 64'd5);

    // clear in the same cycle as a mismatching sample.
    cycle(1, K, K, K ^ 64'h2, 1);
    check("clr.fault_flags", 64'(o0_ff), 64'h4);
    check("clr.sticky", 64'(o0_st), 64'h0);
    check("clr.err_cnt", 64'(o0_err), 64'h0);
    check("clr.lane_failed", 64'(o0_lf), 64'h0);

    // Randomized traffic with a persistent "bad lane" that shifts over time.
    bad = 7;
    for (int n = 0; n < 800; n++) begin
      if (n % 25 == 0) bad = int'($urandom_range(0, 5));
      base = {$urandom, $urandom};
      la = base; lb = base; lc = base;
      if ($urandom_range(0, 9) == 0) la ^= 64'h1 << $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) lb ^= {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) lc ^= 64'h1 << $urandom_range(0, 63);
      if (bad < 3 && $urandom_range(0, 3) != 0) begin
        case (bad)
          0:       la = ~base;
          1:       lb = base + 64'd1;
          default: lc = {$urandom, $urandom};
        endcase
      end
      cycle($urandom_range(0, 3) != 0, la, lb, lc, $urandom_range(0, 79) == 0);
    end

    // Reset with samples in flight in dut1: nothing emerges, all outputs 0.
    cycle(1, K, K, K, 0);
    in_valid = 1'b1; a = ~K; b = ~K; c = ~K;
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    cycle(0, '0, '0, '0, 0);
    cycle(0, '0, '0, '0, 0);
    check("rst_fl.out_valid", 64'(o1_ov), 64'h0);
    check("rst_fl.voted", o1_voted, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
